// File: rtl/cfg_regfile_apb.sv
// APB3 control/status register file: per-channel start/busy/done, enables, GP parameters.
// Optional interrupt (IRQ_EN register and registered irq) when CFG_IRQ_EN is defined.
module cfg_regfile_apb #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned NUM_GP = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic [ADDR_W-1:0]        PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [DATA_W-1:0]        PWDATA,
  output logic [DATA_W-1:0]        PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NUM_CH-1:0]        start_o,
  output logic [4*NUM_CH-1:0]      enables_o,
  output logic [NUM_GP*DATA_W-1:0] gp_o,
  input  logic [NUM_CH-1:0]        done_i,
  output logic [NUM_CH-1:0]        busy_o,
  output logic                     irq
);

  localparam int unsigned WIDX_W  = ADDR_W - 2;
  localparam int unsigned EN_W    = 4 * NUM_CH;
  localparam int unsigned GP_BASE = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [WIDX_W-1:0] widx;
  logic              unused_addr_lsb;
  logic              is_ctrl, is_status, is_enable, is_irqen;
  logic [NUM_GP-1:0] gp_hit;
  logic              addr_ok, ctrl_conflict, err_d;
  logic              commit, wr_ok;
  logic [DATA_W-1:0] rd_data;
  logic [NUM_CH-1:0] busy_q, done_q, busy_d, done_d;
  logic [NUM_CH-1:0] done_acc, start_set, w1c;
`ifdef CFG_IRQ_EN
  logic [NUM_CH-1:0] irq_en_q;
`endif

  assign widx            = PADDR[ADDR_W-1:2];
  assign unused_addr_lsb = ^PADDR[1:0];
  assign busy_o          = busy_q;

  // FSM: one wait state between setup and response
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:   if (PSEL && !PENABLE) state_d = ACCESS;
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_ctrl   = (widx == WIDX_W'(0));
    is_status = (widx == WIDX_W'(1));
    is_enable = (widx == WIDX_W'(2));
`ifdef CFG_IRQ_EN
    is_irqen  = (widx == WIDX_W'(3));
`else
    is_irqen  = 1'b0;
`endif
    gp_hit = '0;
    for (int unsigned k = 0; k < NUM_GP; k++) begin
      gp_hit[k] = (widx == WIDX_W'(GP_BASE + k));
    end
    addr_ok       = is_ctrl | is_status | is_enable | is_irqen | (|gp_hit);
    ctrl_conflict = PWRITE & is_ctrl & (|(PWDATA[NUM_CH-1:0] & busy_q));
    err_d         = ~addr_ok | ctrl_conflict;
    wr_ok         = commit & PWRITE & ~err_d;
  end

  always_comb begin
    rd_data = '0;
    if (is_status) begin
      rd_data[NUM_CH-1:0]   = busy_q;
      rd_data[16 +: NUM_CH] = done_q;
    end
    if (is_enable) rd_data[EN_W-1:0] = enables_o;
`ifdef CFG_IRQ_EN
    if (is_irqen) rd_data[NUM_CH-1:0] = irq_en_q;
`endif
    for (int unsigned k = 0; k < NUM_GP; k++) begin
      if (gp_hit[k]) rd_data = gp_o[k*DATA_W +: DATA_W];
    end
  end

  // A start can only commit on an idle channel, so done_acc never overlaps start_set;
  // done_acc is ORed last so a coincident W1C loses.
  always_comb begin
    done_acc  = done_i & busy_q;
    start_set = (wr_ok && is_ctrl)   ? PWDATA[NUM_CH-1:0]   : '0;
    w1c       = (wr_ok && is_status) ? PWDATA[16 +: NUM_CH] : '0;
    busy_d    = (busy_q & ~done_acc) | start_set;
    done_d    = (done_q & ~w1c) | done_acc;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      start_o   <= '0;
      enables_o <= '0;
      gp_o      <= '0;
      busy_q    <= '0;
      done_q    <= '0;
    end else begin
      if (commit) begin
        PREADY  <= 1'b1;
        PSLVERR <= err_d;
        PRDATA  <= PWRITE ? '0 : rd_data;
      end else if (state_q == RESP) begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
        PRDATA  <= '0;
      end
      start_o <= start_set;
      if (wr_ok && is_enable) enables_o <= PWDATA[EN_W-1:0];
      for (int unsigned k = 0; k < NUM_GP; k++) begin
        if (wr_ok && gp_hit[k]) gp_o[k*DATA_W +: DATA_W] <= PWDATA;
      end
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef CFG_IRQ_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_ok && is_irqen) irq_en_q <= PWDATA[NUM_CH-1:0];
      irq <= |(done_q & irq_en_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_regfile_apb.sv
// Directed bench for cfg_regfile_apb (default parameters); covers CFG_IRQ_EN in either build.
module tb_cfg_regfile_apb;

  logic         PCLK, PRESETn;
  logic [7:0]   PADDR;
  logic         PWRITE, PSEL, PENABLE;
  logic [31:0]  PWDATA, PRDATA;
  logic         PREADY, PSLVERR;
  logic [3:0]   start_o;
  logic [15:0]  enables_o;
  logic [127:0] gp_o;
  logic [3:0]   done_i, busy_o;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;

  // per-transfer observations
  logic [31:0] x_rdata;
  logic        x_err, x_rdy;
  logic [3:0]  s3_start, s4_start, s3_busy;
  logic        s3_irq, s4_irq;

  cfg_regfile_apb #(.ADDR_W(8), .DATA_W(32), .NUM_CH(4), .NUM_GP(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .start_o(start_o), .enables_o(enables_o), .gp_o(gp_o),
    .done_i(done_i), .busy_o(busy_o), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Fixed-length APB transfer; PREADY must be low in cycles 1-2 and high in cycle 3.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] done_at_commit);
    logic r1, r2, r3;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK); r1 = PREADY;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; done_i = done_at_commit;
    @(negedge PCLK); r2 = PREADY;
    @(posedge PCLK); #1;
    done_i = '0;
    @(negedge PCLK);
    r3 = PREADY; x_rdata = PRDATA; x_err = PSLVERR;
    s3_start = start_o; s3_busy = busy_o; s3_irq = irq;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    s4_start = start_o; s4_irq = irq;
    x_rdy = !r1 && !r2 && r3;
  endtask

  task automatic pulse_done(input logic [3:0] m);
    @(posedge PCLK); #1; done_i = m;
    @(posedge PCLK); #1; done_i = '0;
    @(negedge PCLK);
  endtask

  task automatic test_reset;
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; done_i = '0;
    repeat (3) @(negedge PCLK);
    n_vec++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL reset_pready: got %b want 0", PREADY); end
    n_vec++; if (PRDATA !== 32'h0) begin n_err++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
    n_vec++; if (PSLVERR !== 1'b0) begin n_err++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
    n_vec++; if ({start_o, busy_o, enables_o} !== 24'h0) begin n_err++; $display("FAIL reset_ctl: got %h want 0", {start_o, busy_o, enables_o}); end
    n_vec++; if (gp_o !== 128'h0) begin n_err++; $display("FAIL reset_gp: got %h want 0", gp_o); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(posedge PCLK); #1; PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);
  endtask

  task automatic test_enable;
    xfer(1, 8'h08, 32'h0000_00A5, 4'h0);
    n_vec++; if (x_rdy !== 1'b1) begin n_err++; $display("FAIL en_wr_ready: got %b want 1", x_rdy); end
    n_vec++; if (x_err !== 1'b0) begin n_err++; $display("FAIL en_wr_err: got %b want 0", x_err); end
    n_vec++; if (enables_o !== 16'h00A5) begin n_err++; $display("FAIL en_out: got %h want 00a5", enables_o); end
    xfer(0, 8'h08, 32'h0, 4'h0);
    n_vec++; if (x_rdy !== 1'b1) begin n_err++; $display("FAIL en_rd_ready: got %b want 1", x_rdy); end
    n_vec++; if (x_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL en_rd: got %h want 000000a5", x_rdata); end
    n_vec++; if (x_err !== 1'b0) begin n_err++; $display("FAIL en_rd_err: got %b want 0", x_err); end
    xfer(1, 8'h08, 32'hFFFF_FFFF, 4'h0);
    n_vec++; if (enables_o !== 16'hFFFF) begin n_err++; $display("FAIL en_upper_out: got %h want ffff", enables_o); end
    xfer(0, 8'h0B, 32'h0, 4'h0);  // low address bits ignored
    n_vec++; if (x_rdata !== 32'h0000_FFFF) begin n_err++; $display("FAIL en_upper_rd: got %h want 0000ffff", x_rdata); end
    xfer(0, 8'h00, 32'h0, 4'h0);
    n_vec++; if ({x_err, x_rdata} !== 33'h0) begin n_err++; $display("FAIL ctrl_rd: got err=%b data=%h want 0/0", x_err, x_rdata); end
  endtask

  task automatic test_start_done;
    xfer(1, 8'h00, 32'h1, 4'h0);
    n_vec++; if (x_err !== 1'b0) begin n_err++; $display("FAIL start_err: got %b want 0", x_err); end
    n_vec++; if (s3_start !== 4'b0001) begin n_err++; $display("FAIL start_pulse: got %b want 0001", s3_start); end
    n_vec++; if (s4_start !== 4'b0000) begin n_err++; $display("FAIL start_one_cycle: got %b want 0000", s4_start); end
    n_vec++; if (s3_busy !== 4'b0001) begin n_err++; $display("FAIL start_busy: got %b want 0001", s3_busy); end
    pulse_done(4'b0001);
    n_vec++; if (busy_o !== 4'b0000) begin n_err++; $display("FAIL done_busy: got %b want 0000", busy_o); end
    xfer(0, 8'h04, 32'h0, 4'h0);
    n_vec++; if (x_rdata !== 32'h0001_0000) begin n_err++; $display("FAIL status_done: got %h want 00010000", x_rdata); end
    xfer(1, 8'h04, 32'h0001_0000, 4'h0);
    xfer(0, 8'h04, 32'h0, 4'h0);
    n_vec++; if (x_rdata !== 32'h0) begin n_err++; $display("FAIL status_w1c: got %h want 0", x_rdata); end
  endtask

  task automatic test_busy_conflict;
    xfer(1, 8'h00, 32'h2, 4'h0);
    n_vec++; if (s3_busy !== 4'b0010) begin n_err++; $display("FAIL ch1_busy: got %b want 0010", s3_busy); end
    xfer(1, 8'h00, 32'h3, 4'h0);
    n_vec++; if (x_err !== 1'b1) begin n_err++; $display("FAIL conflict_err: got %b want 1", x_err); end
    n_vec++; if ({s3_start, s4_start} !== 8'h00) begin n_err++; $display("FAIL conflict_start: got %h want 00", {s3_start, s4_start}); end
    n_vec++; if (busy_o !== 4'b0010) begin n_err++; $display("FAIL conflict_busy: got %b want 0010", busy_o); end
    pulse_done(4'b1010);  // ch3 not busy: ignored
    xfer(0, 8'h04, 32'h0, 4'h0);
    n_vec++; if (x_rdata !== 32'h0002_0000) begin n_err++; $display("FAIL idle_done_ignored: got %h want 00020000", x_rdata); end
    xfer(1, 8'h04, 32'h000F_0000, 4'h0);
  endtask

  task automatic test_bad_addr;
    logic [15:0]  en_before;
    logic [127:0] gp_before;
    xfer(0, 8'h40, 32'h0, 4'h0);
    n_vec++; if ({x_err, x_rdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL bad_rd: got err=%b data=%h want 1/0", x_err, x_rdata); end
    en_before = enables_o; gp_before = gp_o;
    xfer(1, 8'h40, 32'hFFFF_FFFF, 4'h0);
    n_vec++; if (x_err !== 1'b1) begin n_err++; $display("FAIL bad_wr_err: got %b want 1", x_err); end
    n_vec++; if ({enables_o, gp_o, busy_o} !== {en_before, gp_before, 4'h0}) begin n_err++; $display("FAIL bad_wr_state: got %h/%h want %h/%h", enables_o, gp_o, en_before, gp_before); end
    xfer(0, 8'h20, 32'h0, 4'h0);
    n_vec++; if (x_err !== 1'b1) begin n_err++; $display("FAIL gp_end_err: got %b want 1", x_err); end
    xfer(0, 8'h1C, 32'h0, 4'h0);
    n_vec++; if (x_err !== 1'b0) begin n_err++; $display("FAIL gp_last_err: got %b want 0", x_err); end
    xfer(0, 8'h0C, 32'h0, 4'h0);
`ifdef CFG_IRQ_EN
    n_vec++; if (x_err !== 1'b0) begin n_err++; $display("FAIL irqen_err: got %b want 0", x_err); end
`else
    n_vec++; if ({x_err, x_rdata} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL irqen_absent: got err=%b data=%h want 1/0", x_err, x_rdata); end
`endif
  endtask

  task automatic test_w1c_race;
    xfer(1, 8'h00, 32'h4, 4'h0);
    pulse_done(4'b0100);
    xfer(1, 8'h00, 32'h4, 4'h0);
    n_vec++; if (s3_busy !== 4'b0100) begin n_err++; $display("FAIL rerun_busy: got %b want 0100", s3_busy); end
    xfer(1, 8'h04, 32'h0004_0000, 4'b0100);
    xfer(0, 8'h04, 32'h0, 4'h0);
    n_vec++; if (x_rdata !== 32'h0004_0000) begin n_err++; $display("FAIL race_set_wins: got %h want 00040000", x_rdata); end
    xfer(1, 8'h04, 32'h0004_0000, 4'h0);
    xfer(0, 8'h04, 32'h0, 4'h0);
    n_vec++; if (x_rdata !== 32'h0) begin n_err++; $display("FAIL race_clear: got %h want 0", x_rdata); end
  endtask

  task automatic test_gp;
    xfer(1, 8'h1C, 32'hDEAD_BEEF, 4'h0);
    n_vec++; if (gp_o[127:96] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL gp3_out: got %h want deadbeef", gp_o[127:96]); end
    xfer(1, 8'h10, 32'h1234_5678, 4'h0);
    n_vec++; if (gp_o[31:0] !== 32'h1234_5678) begin n_err++; $display("FAIL gp0_out: got %h want 12345678", gp_o[31:0]); end
    n_vec++; if (gp_o[95:32] !== 64'h0) begin n_err++; $display("FAIL gp12_out: got %h want 0", gp_o[95:32]); end
    xfer(0, 8'h1C, 32'h0, 4'h0);
    n_vec++; if (x_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL gp3_rd: got %h want deadbeef", x_rdata); end
  endtask

  task automatic test_irq;
`ifdef CFG_IRQ_EN
    xfer(1, 8'h0C, 32'h1, 4'h0);
    xfer(1, 8'h00, 32'h1, 4'h0);
    pulse_done(4'b0001);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
    @(negedge PCLK);
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
    xfer(1, 8'h04, 32'h0001_0000, 4'h0);
    n_vec++; if ({s3_irq, s4_irq} !== 2'b10) begin n_err++; $display("FAIL irq_w1c: got %b want 10", {s3_irq, s4_irq}); end
    xfer(1, 8'h00, 32'h1, 4'h0);
    pulse_done(4'b0001);
    @(negedge PCLK);
    xfer(1, 8'h0C, 32'h0, 4'h0);
    n_vec++; if ({s3_irq, s4_irq} !== 2'b10) begin n_err++; $display("FAIL irq_en_clear: got %b want 10", {s3_irq, s4_irq}); end
    xfer(1, 8'h04, 32'h0001_0000, 4'h0);
`else
    xfer(1, 8'h00, 32'h1, 4'h0);
    pulse_done(4'b0001);
    repeat (2) @(negedge PCLK);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_tied: got %b want 0", irq); end
    xfer(1, 8'h04, 32'h0001_0000, 4'h0);
`endif
  endtask

  task automatic test_reset_mid;
    xfer(1, 8'h00, 32'h2, 4'h0);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'h08; PWDATA = 32'h0000_0055;
    @(posedge PCLK); #1;
    PENABLE = 1;
    #2 PRESETn = 1'b0;
    #1;
    n_vec++; if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin n_err++; $display("FAIL midrst_apb: got %h want 0", {PREADY, PSLVERR, PRDATA}); end
    n_vec++; if ({start_o, busy_o, enables_o, irq} !== 25'h0) begin n_err++; $display("FAIL midrst_ctl: got %h want 0", {start_o, busy_o, enables_o, irq}); end
    n_vec++; if (gp_o !== 128'h0) begin n_err++; $display("FAIL midrst_gp: got %h want 0", gp_o); end
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; PRESETn = 1'b1;
    xfer(0, 8'h08, 32'h0, 4'h0);
    n_vec++; if (x_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_lost: got %h want 0", x_rdata); end
  endtask

  initial begin
    test_reset;
    test_enable;
    test_start_done;
    test_busy_conflict;
    test_bad_addr;
    test_w1c_race;
    test_gp;
    test_irq;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
